// File: rtl/round_robin_request_arbiter_if.sv
// Bundle of the upstream request ports and the downstream registered request stream.
// No logic of its own; the arbiter side uses the slave modport and the environment uses master.
// Backpressure is carried by issue_ack_in (downstream) and issue_ack_packed_out (upstream).
interface round_robin_request_arbiter_if #(
    parameter int NUM_REQUEST                = 4,
    parameter int NUM_REQUEST_WIDTH          = $clog2(NUM_REQUEST),
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64
);
    logic [NUM_REQUEST*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in;
    logic [NUM_REQUEST-1:0]                            request_valid_packed_in;
    logic [NUM_REQUEST-1:0]                            issue_ack_packed_out;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]             request_out;
    logic                                              request_valid_out;
    logic [NUM_REQUEST_WIDTH-1:0]                      request_source_out;
    logic                                              issue_ack_in;

    // Arbiter side
    modport slave (
        input  request_packed_in,
        input  request_valid_packed_in,
        output issue_ack_packed_out,
        output request_out,
        output request_valid_out,
        output request_source_out,
        input  issue_ack_in
    );

    // Requesters plus downstream consumer side
    modport master (
        output request_packed_in,
        output request_valid_packed_in,
        input  issue_ack_packed_out,
        input  request_out,
        input  request_valid_out,
        input  request_source_out,
        output issue_ack_in
    );
endinterface

// File: rtl/round_robin_request_arbiter.sv
// Round-robin merge of NUM_REQUEST request ports into one registered request entry.
// Latency: one cycle from a granted request to request_valid_out; one grant per cycle when acked.
// Backpressure: a held entry blocks all grants until issue_ack_in frees the slot in place.
module round_robin_request_arbiter #(
    parameter int NUM_REQUEST                = 4,
    parameter int NUM_REQUEST_WIDTH          = $clog2(NUM_REQUEST),
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    round_robin_request_arbiter_if.slave   bus
);
    localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int IW = NUM_REQUEST_WIDTH;
    localparam logic [IW:0] NUM_EXT  = (IW+1)'(NUM_REQUEST);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQUEST - 1);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t          state;
    logic [IW-1:0]   pointer;
    logic            slot_free;
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [IW:0]     scan_sum;
    logic [IW-1:0]   scan_idx;
    logic [W-1:0]    grant_payload;

    // The entry can be (re)loaded when empty or when downstream takes it this cycle.
    assign slot_free = (state == EMPTY) || bus.issue_ack_in;

    // Scan ports starting at the pointer and wrapping; the first valid port wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQUEST; k++) begin
            scan_sum = {1'b0, pointer} + (IW+1)'(k);
            if (scan_sum >= NUM_EXT) begin
                scan_sum = scan_sum - NUM_EXT;
            end
            scan_idx = scan_sum[IW-1:0];
            if (!grant_found && bus.request_valid_packed_in[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Payload of the winning port.
    always_comb begin
        grant_payload = bus.request_packed_in[int'(grant_idx)*W +: W];
    end

    // One-hot accept to the winner; forced quiet while reset is held.
    always_comb begin
        bus.issue_ack_packed_out = '0;
        if (!reset_in && slot_free && grant_found) begin
            bus.issue_ack_packed_out = NUM_REQUEST'(1) << grant_idx;
        end
    end

    // Entry FSM: load on grant, clear when freed with nobody waiting, hold otherwise.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state                  <= EMPTY;
            pointer                <= '0;
            bus.request_out        <= '0;
            bus.request_valid_out  <= 1'b0;
            bus.request_source_out <= '0;
        end else if (slot_free) begin
            if (grant_found) begin
                state                  <= HOLD;
                bus.request_out        <= grant_payload;
                bus.request_source_out <= grant_idx;
                bus.request_valid_out  <= 1'b1;
                pointer                <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
            end else begin
                state                  <= EMPTY;
                bus.request_out        <= '0;
                bus.request_valid_out  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_round_robin_request_arbiter.sv
// Bench for round_robin_request_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-free entry/pointer model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_round_robin_request_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W  = 64;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b1;
    int   total    = 0;
    int   passed   = 0;

    logic [W-1:0] payload [N];

    round_robin_request_arbiter_if #(.NUM_REQUEST(N), .NUM_REQUEST_WIDTH(IW),
                                     .SINGLE_ENTRY_WIDTH_IN_BITS(W)) bus ();

    round_robin_request_arbiter #(.NUM_REQUEST(N), .NUM_REQUEST_WIDTH(IW),
                                  .SINGLE_ENTRY_WIDTH_IN_BITS(W)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.request_packed_in[i*W +: W] = payload[i];
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the nearest valid port at or after the pointer (cyclic distance) wins.
    function automatic int pick(input logic [N-1:0] vld, input int ptr);
        int best, bestd, d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (vld[i]) begin
                d = (i - ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    logic         m_vld;
    logic [W-1:0] m_dat;
    int           m_src;
    int           m_ptr;

    // Model state advance on each edge.
    always @(posedge clk_in or posedge reset_in) begin
        int g;
        if (reset_in) begin
            m_vld <= 1'b0;
            m_dat <= '0;
            m_src <= 0;
            m_ptr <= 0;
        end else if (!m_vld || bus.issue_ack_in) begin
            g = pick(bus.request_valid_packed_in, m_ptr);
            if (g >= 0) begin
                m_vld <= 1'b1;
                m_dat <= payload[g];
                m_src <= g;
                m_ptr <= (g + 1) % N;
            end else begin
                m_vld <= 1'b0;
                m_dat <= '0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_in) begin
        int g;
        logic [N-1:0] exp_ack;
        if (!reset_in) begin
            exp_ack = '0;
            g = pick(bus.request_valid_packed_in, m_ptr);
            if ((!m_vld || bus.issue_ack_in) && g >= 0) begin
                exp_ack[g] = 1'b1;
            end
            check("model_ack",   W'(bus.issue_ack_packed_out), W'(exp_ack));
            check("model_valid", W'(bus.request_valid_out),    W'(m_vld));
            check("model_data",  bus.request_out,              m_dat);
            check("model_src",   W'(bus.request_source_out),   W'(m_src[IW-1:0]));
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [W-1:0] held;
        bus.request_valid_packed_in = '0;
        bus.issue_ack_in = 1'b0;
        for (int i = 0; i < N; i++) payload[i] = W'(64'h1000 + i);
        #1;
        check("reset_valid", W'(bus.request_valid_out), '0);
        check("reset_data",  bus.request_out, '0);
        check("reset_ack",   W'(bus.issue_ack_packed_out), '0);
        tick();
        tick();
        reset_in = 1'b0;

        // All ports valid, downstream always ready: grants rotate 0,1,2,3,0 with no bubble.
        bus.request_valid_packed_in = 4'b1111;
        bus.issue_ack_in = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("rotate_ack", W'(bus.issue_ack_packed_out), W'(4'b0001 << (s % N)));
            tick();
            check("rotate_valid", W'(bus.request_valid_out), W'(1'b1));
            check("rotate_src", W'(bus.request_source_out), W'(s % N));
        end

        // Backpressure: entry from port 0 held while ports 1 and 3 wait.
        bus.request_valid_packed_in = 4'b1010;
        bus.issue_ack_in = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("bp_ack", W'(bus.issue_ack_packed_out), '0);
            check("bp_data", bus.request_out, 64'h1000);
            tick();
        end
        bus.issue_ack_in = 1'b1;
        #1;
        check("bp_release_ack", W'(bus.issue_ack_packed_out), W'(4'b0010));
        tick();
        check("bp_release_src", W'(bus.request_source_out), W'(1));
        check("bp_release_data", bus.request_out, 64'h1001);

        // Single requester on port 2.
        payload[2] = 64'hA5;
        bus.request_valid_packed_in = 4'b0100;
        #1;
        check("single_ack", W'(bus.issue_ack_packed_out), W'(4'b0100));
        tick();
        bus.request_valid_packed_in = 4'b0000;
        bus.issue_ack_in = 1'b0;
        #1;
        check("single_valid", W'(bus.request_valid_out), W'(1'b1));
        check("single_data",  bus.request_out, 64'hA5);
        check("single_src",   W'(bus.request_source_out), W'(2));

        // Wrap: pointer is 3, ports 0 and 3 valid.
        bus.request_valid_packed_in = 4'b1001;
        bus.issue_ack_in = 1'b1;
        #1;
        check("wrap_ack3", W'(bus.issue_ack_packed_out), W'(4'b1000));
        tick();
        bus.request_valid_packed_in = 4'b0001;
        #1;
        check("wrap_src3", W'(bus.request_source_out), W'(3));
        check("wrap_ack0", W'(bus.issue_ack_packed_out), W'(4'b0001));
        tick();
        bus.request_valid_packed_in = 4'b0000;
        #1;
        check("wrap_src0", W'(bus.request_source_out), W'(0));

        // Drain, then an ack while empty changes nothing.
        tick();
        check("drain_valid", W'(bus.request_valid_out), '0);
        check("drain_data",  bus.request_out, '0);
        tick();
        check("empty_ack_valid", W'(bus.request_valid_out), '0);
        check("empty_ack_src",   W'(bus.request_source_out), W'(0));

        // Asynchronous reset in the middle of a held entry.
        bus.issue_ack_in = 1'b0;
        bus.request_valid_packed_in = 4'b0100;
        tick();
        bus.request_valid_packed_in = 4'b0000;
        #1;
        check("pre_reset_valid", W'(bus.request_valid_out), W'(1'b1));
        reset_in = 1'b1;
        bus.request_valid_packed_in = 4'b1111;
        #1;
        check("async_reset_valid", W'(bus.request_valid_out), '0);
        check("async_reset_data",  bus.request_out, '0);
        check("async_reset_src",   W'(bus.request_source_out), '0);
        check("async_reset_ack",   W'(bus.issue_ack_packed_out), '0);
        tick();
        reset_in = 1'b0;
        bus.issue_ack_in = 1'b1;
        #1;
        check("post_reset_ack", W'(bus.issue_ack_packed_out), W'(4'b0001));
        tick();
        check("post_reset_src", W'(bus.request_source_out), W'(0));

        // Random traffic, including withdrawals and stalls.
        for (int c = 0; c < 3000; c++) begin
            held = {$urandom, $urandom};
            payload[c % N] = held;
            bus.request_valid_packed_in = N'($urandom);
            bus.issue_ack_in = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
